// File: rtl/timebase_ticker.sv
//----------------------------------------------------------------------------
// Module      : timebase_ticker
// Description : Parametrised timebase generator. A prescaler divides the
//               input clock down to a base tick at TICKS_PER_SEC Hz. Two
//               cascaded modulo counters then produce second and minute
//               ticks. The in-second and in-minute counts are exposed.
//               'enable' pauses every counter without losing phase, and
//               'clear' restarts every counter synchronously.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Configuration macro:
//   TIMEBASE_MINUTE_EN  defined   -> sec_count counter and min_tick are built
//                       undefined -> minute stage removed; sec_count and
//                                    min_tick are tied to 0
//----------------------------------------------------------------------------
// Ports:
//   clock      in   1      system clock, rising edge
//   resetn     in   1      asynchronous active-low reset
//   enable     in   1      run when 1, hold (pause) when 0
//   clear      in   1      synchronous restart of all counters (beats enable)
//   tick       out  1      one-cycle pulse per base period
//   sec_tick   out  1      one-cycle pulse per second, coincident with tick
//   min_tick   out  1      one-cycle pulse per minute, coincident with sec_tick
//   sub_count  out  SUB_W  base ticks elapsed in the current second
//   sec_count  out  SEC_W  seconds elapsed in the current minute
//----------------------------------------------------------------------------
`default_nettype none

module timebase_ticker #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TICKS_PER_SEC   = 10,
    parameter int SEC_PER_MIN     = 60,
    // Derived widths; not intended to be overridden
    parameter int DIV_W = ((CLOCK_FREQUENCY / TICKS_PER_SEC) > 1) ?
                          $clog2(CLOCK_FREQUENCY / TICKS_PER_SEC) : 1,
    parameter int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1,
    parameter int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             clear,
    output logic             tick,
    output logic             sec_tick,
    output logic             min_tick,
    output logic [SUB_W-1:0] sub_count,
    output logic [SEC_W-1:0] sec_count
);

    localparam int DIV = CLOCK_FREQUENCY / TICKS_PER_SEC;

    localparam logic [DIV_W-1:0] C_DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [SUB_W-1:0] C_SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);

    // Reject configurations that cannot produce an exact base rate.
    if ((CLOCK_FREQUENCY % TICKS_PER_SEC) != 0) begin : g_bad_ratio
        $error("timebase_ticker: CLOCK_FREQUENCY must be a multiple of TICKS_PER_SEC");
    end
    if (DIV < 1) begin : g_bad_div
        $error("timebase_ticker: CLOCK_FREQUENCY/TICKS_PER_SEC must be at least 1");
    end

    logic [DIV_W-1:0] r_div_cnt;
    logic [SUB_W-1:0] r_sub_cnt;
    logic             r_tick;
    logic             r_sec_tick;

    logic             w_base;      // prescaler at terminal count
    logic             w_sub_last;  // sub counter at its final value
    logic             w_sec_event; // a second boundary is taken on this edge

    assign w_base      = (r_div_cnt == '0);
    assign w_sub_last  = (r_sub_cnt == C_SUB_LAST);
    // clear discards a coincident terminal count, a paused edge takes nothing
    assign w_sec_event = !clear && enable && w_base && w_sub_last;

    //------------------------------------------------------------------------
    // Prescaler and sub-second counter
    //------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_div_cnt  <= C_DIV_RELOAD;
            r_sub_cnt  <= '0;
            r_tick     <= 1'b0;
            r_sec_tick <= 1'b0;
        end else if (clear) begin
            r_div_cnt  <= C_DIV_RELOAD;
            r_sub_cnt  <= '0;
            r_tick     <= 1'b0;
            r_sec_tick <= 1'b0;
        end else if (enable) begin
            r_tick     <= w_base;
            r_sec_tick <= w_base && w_sub_last;
            if (w_base) begin
                r_div_cnt <= C_DIV_RELOAD;
                r_sub_cnt <= w_sub_last ? '0 : r_sub_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt - 1'b1;
            end
        end else begin
            // Paused: counts hold, so the pending period simply stretches.
            r_tick     <= 1'b0;
            r_sec_tick <= 1'b0;
        end
    end

    assign tick      = r_tick;
    assign sec_tick  = r_sec_tick;
    assign sub_count = r_sub_cnt;

    //------------------------------------------------------------------------
    // Minute stage
    //------------------------------------------------------------------------
`ifdef TIMEBASE_MINUTE_EN
    localparam logic [SEC_W-1:0] C_SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

    logic [SEC_W-1:0] r_sec_cnt;
    logic             r_min_tick;
    logic             w_sec_last;

    assign w_sec_last = (r_sec_cnt == C_SEC_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sec_cnt  <= '0;
            r_min_tick <= 1'b0;
        end else if (clear || !enable) begin
            // clear restarts the minute; a pause only drops the pulse
            if (clear) begin
                r_sec_cnt <= '0;
            end
            r_min_tick <= 1'b0;
        end else begin
            r_min_tick <= w_sec_event && w_sec_last;
            if (w_sec_event) begin
                r_sec_cnt <= w_sec_last ? '0 : r_sec_cnt + 1'b1;
            end
        end
    end

    assign sec_count = r_sec_cnt;
    assign min_tick  = r_min_tick;
`else
    logic w_unused_sec_event;
    assign w_unused_sec_event = w_sec_event;

    assign sec_count = '0;
    assign min_tick  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_timebase_ticker.sv
//----------------------------------------------------------------------------
// Module      : tb_timebase_ticker
// Description : Self-checking bench for timebase_ticker. Two instances share
//               the stimulus: DIV=2 (20 Hz clock, 10 ticks/s, 3 s/min) and
//               DIV=1 (10 Hz clock). A reference model pushes expected
//               outputs into a queue as each input is driven; the queue is
//               popped and compared after the corresponding clock edge.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_timebase_ticker;

    localparam int TPS = 10;
    localparam int SPM = 3;
`ifdef TIMEBASE_MINUTE_EN
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;

    logic       tick0, sec_tick0, min_tick0;
    logic [3:0] sub_count0;
    logic [1:0] sec_count0;
    logic       tick1, sec_tick1, min_tick1;
    logic [3:0] sub_count1;
    logic [1:0] sec_count1;

    timebase_ticker #(
        .CLOCK_FREQUENCY(20), .TICKS_PER_SEC(TPS), .SEC_PER_MIN(SPM)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear),
        .tick(tick0), .sec_tick(sec_tick0), .min_tick(min_tick0),
        .sub_count(sub_count0), .sec_count(sec_count0)
    );

    timebase_ticker #(
        .CLOCK_FREQUENCY(10), .TICKS_PER_SEC(TPS), .SEC_PER_MIN(SPM)
    ) dut1 (
        .clock(clock), .resetn(resetn), .enable(enable), .clear(clear),
        .tick(tick1), .sec_tick(sec_tick1), .min_tick(min_tick1),
        .sub_count(sub_count1), .sec_count(sec_count1)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        int div; int sub; int sec;
        bit tick; bit st; bit mt;
    } mstate_t;

    typedef struct {
        bit t0; bit st0; bit mt0; int sub0; int sec0;
        bit t1; bit st1; bit mt1; int sub1; int sec1;
    } exp_t;

    function automatic mstate_t mreset(int dv);
        mstate_t s;
        s.div = dv - 1; s.sub = 0; s.sec = 0;
        s.tick = 0; s.st = 0; s.mt = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s_in, int dv, bit en, bit clr);
        mstate_t s = s_in;
        if (clr) begin
            s = mreset(dv);
        end else if (en) begin
            s.tick = (s.div == 0);
            s.st = 0; s.mt = 0;
            if (s.div == 0) begin
                s.div = dv - 1;
                if (s.sub == TPS - 1) begin
                    s.sub = 0;
                    s.st = 1;
                    if (MIN_EN) begin
                        if (s.sec == SPM - 1) begin
                            s.sec = 0;
                            s.mt = 1;
                        end else begin
                            s.sec = s.sec + 1;
                        end
                    end
                end else begin
                    s.sub = s.sub + 1;
                end
            end else begin
                s.div = s.div - 1;
            end
        end else begin
            s.tick = 0; s.st = 0; s.mt = 0;
        end
        return s;
    endfunction

    mstate_t m0, m1;
    exp_t    exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    int cnt_st0, cnt_mt0, cnt_t1, cnt_st1;
    int first_t0_edge, first_st0_edge, first_mt0_edge;

    task automatic clear_stats();
        cnt_st0 = 0; cnt_mt0 = 0; cnt_t1 = 0; cnt_st1 = 0;
        first_t0_edge = -1; first_st0_edge = -1; first_mt0_edge = -1;
    endtask

    task automatic check_int(string name, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), predict, then
    // compare just after the following rising edge.
    task automatic step(input bit en, input bit clr);
        exp_t e;
        enable = en;
        clear  = clr;
        m0 = mstep(m0, 2, en, clr);
        m1 = mstep(m1, 1, en, clr);
        e.t0 = m0.tick; e.st0 = m0.st; e.mt0 = m0.mt; e.sub0 = m0.sub; e.sec0 = m0.sec;
        e.t1 = m1.tick; e.st1 = m1.st; e.mt1 = m1.mt; e.sub1 = m1.sub; e.sec1 = m1.sec;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        edge_no++;
        e = exp_q.pop_front();
        n_checks++;
        if (tick0 !== e.t0 || sec_tick0 !== e.st0 || min_tick0 !== e.mt0 ||
            int'(sub_count0) != e.sub0 || int'(sec_count0) != e.sec0 ||
            tick1 !== e.t1 || sec_tick1 !== e.st1 || min_tick1 !== e.mt1 ||
            int'(sub_count1) != e.sub1 || int'(sec_count1) != e.sec1) begin
            n_fail++;
            $display("FAIL step edge %0d: got div2 t/s/m=%0b%0b%0b sub=%0d sec=%0d div1 t/s/m=%0b%0b%0b sub=%0d sec=%0d; expected div2 %0b%0b%0b sub=%0d sec=%0d div1 %0b%0b%0b sub=%0d sec=%0d",
                     edge_no, tick0, sec_tick0, min_tick0, sub_count0, sec_count0,
                     tick1, sec_tick1, min_tick1, sub_count1, sec_count1,
                     e.t0, e.st0, e.mt0, e.sub0, e.sec0,
                     e.t1, e.st1, e.mt1, e.sub1, e.sec1);
        end
        if (tick0 && first_t0_edge < 0) first_t0_edge = edge_no;
        if (sec_tick0) begin
            cnt_st0++;
            if (first_st0_edge < 0) begin
                first_st0_edge = edge_no;
                check_int("sub_count at first sec_tick", int'(sub_count0), 0);
            end
        end
        if (min_tick0) begin
            cnt_mt0++;
            if (first_mt0_edge < 0) first_mt0_edge = edge_no;
        end
        if (tick1) cnt_t1++;
        if (sec_tick1) cnt_st1++;
        @(negedge clock);
    endtask

    // Hold reset across a rising edge, release at a falling edge.
    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_int("outputs held in reset",
                  int'({tick0, sec_tick0, min_tick0, sub_count0, sec_count0,
                        tick1, sec_tick1, min_tick1, sub_count1, sec_count1}), 0);
        resetn = 1'b1;
        m0 = mreset(2);
        m1 = mreset(1);
        edge_no = 0;
        clear_stats();
    endtask

    // Pause table: {enable, clear, tick, sec_tick, sub_count} for DIV=2
    typedef struct {
        bit en; bit clr; bit t; bit st; int sub;
    } vec_t;
    vec_t vtab[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vtab[0]  = '{1, 0, 0, 0, 0};
        vtab[1]  = '{1, 0, 1, 0, 1};
        vtab[2]  = '{1, 0, 0, 0, 1};
        vtab[3]  = '{0, 0, 0, 0, 1};
        vtab[4]  = '{0, 0, 0, 0, 1};
        vtab[5]  = '{0, 0, 0, 0, 1};
        vtab[6]  = '{0, 0, 0, 0, 1};
        vtab[7]  = '{0, 0, 0, 0, 1};
        vtab[8]  = '{1, 0, 1, 0, 2};
        vtab[9]  = '{1, 0, 0, 0, 2};
        vtab[10] = '{1, 0, 1, 0, 3};
        vtab[11] = '{1, 0, 0, 0, 3};

        // 1/5/6: free run from reset release
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
        check_int("first tick edge", first_t0_edge, 2);
        check_int("first sec_tick edge", first_st0_edge, 20);
        check_int("sec_tick count in 200 edges", cnt_st0, 10);
        check_int("first min_tick edge", first_mt0_edge, MIN_EN ? 60 : -1);
        check_int("min_tick count in 200 edges", cnt_mt0, MIN_EN ? 3 : 0);
        check_int("DIV=1 tick count", cnt_t1, 200);
        check_int("DIV=1 sec_tick count", cnt_st1, 20);

        // 2: pause for 5 cycles after edge 3
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(vtab[i].en, vtab[i].clr);
            check_int($sformatf("pause table row %0d tick", i), int'(tick0), int'(vtab[i].t));
            check_int($sformatf("pause table row %0d sec_tick", i), int'(sec_tick0), int'(vtab[i].st));
            check_int($sformatf("pause table row %0d sub_count", i), int'(sub_count0), vtab[i].sub);
        end

        // 3: clear on the second terminal edge
        do_reset();
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_int("tick after clear", int'(tick0), 0);
        check_int("sec_tick after clear", int'(sec_tick0), 0);
        check_int("sub_count after clear", int'(sub_count0), 0);
        step(1'b1, 1'b0);
        check_int("tick at edge 21", int'(tick0), 0);
        step(1'b1, 1'b0);
        check_int("tick at edge 22", int'(tick0), 1);

        // 4: asynchronous reset between edges
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        resetn = 1'b0;
        #1;
        check_int("outputs right after async reset",
                  int'({tick0, sec_tick0, min_tick0, sub_count0, sec_count0,
                        tick1, sec_tick1, min_tick1, sub_count1, sec_count1}), 0);
        @(negedge clock);
        resetn = 1'b1;
        m0 = mreset(2);
        m1 = mreset(1);
        edge_no = 0;
        clear_stats();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check_int("first tick after reset release", first_t0_edge, 2);

        // Mixed enable/clear stress against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
